// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the fetch/mem-stage memory arbiter: FSM state
// encoding, transaction owner codes and the owner-selection helper.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic OWN_INST = 1'b0;
    localparam logic OWN_DATA = 1'b1;

    // When both stages are waiting, the priority parameter decides who goes first.
    function automatic logic pick_owner(input logic need_i,
                                        input logic need_d,
                                        input logic data_first);
        logic owner;
        owner = OWN_INST;
        if (need_i && need_d) begin
            owner = data_first ? OWN_DATA : OWN_INST;
        end else if (need_d) begin
            owner = OWN_DATA;
        end
        return owner;
    endfunction

endpackage

// File: rtl/mem_arbiter_req_reg.sv
// Holding register for the fields of the request currently presented to
// memory; loaded once per transaction so the fields stay stable until ack.
module mem_req_reg #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_load,
    input  logic            i_we,
    input  logic [DW/8-1:0] i_be,
    input  logic [AW-1:0]   i_addr,
    input  logic [DW-1:0]   i_wdata,
    output logic            o_we,
    output logic [DW/8-1:0] o_be,
    output logic [AW-1:0]   o_addr,
    output logic [DW-1:0]   o_wdata
);

    logic            r_we;
    logic [DW/8-1:0] r_be;
    logic [AW-1:0]   r_addr;
    logic [DW-1:0]   r_wdata;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_we    <= 1'b0;
            r_be    <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (i_load) begin
            r_we    <= i_we;
            r_be    <= i_be;
            r_addr  <= i_addr;
            r_wdata <= i_wdata;
        end
    end

    assign o_we    = r_we;
    assign o_be    = r_be;
    assign o_addr  = r_addr;
    assign o_wdata = r_wdata;

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between instruction fetch and the mem stage,
// one transaction at a time, stalling the pipeline until both are served.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter bit DATA_FIRST = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            inst_req,
    input  logic [AW-1:0]   inst_addr,
    output logic [DW-1:0]   inst_rdata,
    input  logic            data_req,
    input  logic            data_we,
    input  logic [DW/8-1:0] data_be,
    input  logic [AW-1:0]   data_addr,
    input  logic [DW-1:0]   data_wdata,
    output logic [DW-1:0]   data_rdata,
    output logic            stall,
    output logic            mem_req,
    output logic            mem_we,
    output logic [DW/8-1:0] mem_be,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    input  logic            mem_ack,
    input  logic            mem_rvalid,
    input  logic [DW-1:0]   mem_rdata
);

    state_t          r_state;
    logic            r_owner;
    logic            r_mem_req;
    logic            r_inst_done;
    logic            r_data_done;
    logic [DW-1:0]   r_inst_rdata;
    logic [DW-1:0]   r_data_rdata;

    logic            w_need_i;
    logic            w_need_d;
    logic            w_stall;
    logic            w_issue;
    logic            w_sel_owner;
    logic            w_resp;
    logic            w_ld_we;
    logic [DW/8-1:0] w_ld_be;
    logic [AW-1:0]   w_ld_addr;
    logic [DW-1:0]   w_ld_wdata;
    logic            w_mem_we;

    assign w_need_i    = inst_req & ~r_inst_done;
    assign w_need_d    = data_req & ~r_data_done;
    // Stall is forced low while reset is held so the pipeline is not frozen.
    assign w_stall     = rst & (w_need_i | w_need_d);
    assign w_issue     = (r_state == ST_IDLE) & (w_need_i | w_need_d);
    assign w_sel_owner = pick_owner(w_need_i, w_need_d, DATA_FIRST);
    assign w_resp      = (r_state == ST_RESP) & mem_rvalid;

    // Reads (fetches and loads) always use full byte enables.
    always_comb begin
        w_ld_we    = 1'b0;
        w_ld_be    = '1;
        w_ld_addr  = inst_addr;
        w_ld_wdata = '0;
        if (w_sel_owner == OWN_DATA) begin
            w_ld_we    = data_we;
            w_ld_be    = data_we ? data_be : '1;
            w_ld_addr  = data_addr;
            w_ld_wdata = data_wdata;
        end
    end

    mem_req_reg #(
        .AW (AW),
        .DW (DW)
    ) u_req_reg (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_load  (w_issue),
        .i_we    (w_ld_we),
        .i_be    (w_ld_be),
        .i_addr  (w_ld_addr),
        .i_wdata (w_ld_wdata),
        .o_we    (w_mem_we),
        .o_be    (mem_be),
        .o_addr  (mem_addr),
        .o_wdata (mem_wdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_owner   <= OWN_INST;
            r_mem_req <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_issue) begin
                        r_owner   <= w_sel_owner;
                        r_mem_req <= 1'b1;
                        r_state   <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (mem_ack) begin
                        r_mem_req <= 1'b0;
                        r_state   <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (mem_rvalid) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_mem_req <= 1'b0;
                end
            endcase
        end
    end

    // Done flags: an unstalled edge means the pipeline advances, so forget them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_inst_done <= 1'b0;
            r_data_done <= 1'b0;
        end else if (!w_stall) begin
            r_inst_done <= 1'b0;
            r_data_done <= 1'b0;
        end else if (w_resp) begin
            if (r_owner == OWN_INST) begin
                r_inst_done <= 1'b1;
            end else begin
                r_data_done <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_inst_rdata <= '0;
            r_data_rdata <= '0;
        end else if (w_resp) begin
            if (r_owner == OWN_INST) begin
                r_inst_rdata <= mem_rdata;
            end else if (!w_mem_we) begin
                r_data_rdata <= mem_rdata;
            end
        end
    end

    assign stall      = w_stall;
    assign mem_req    = r_mem_req;
    assign mem_we     = w_mem_we;
    assign inst_rdata = r_inst_rdata;
    assign data_rdata = r_data_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: one instance per priority setting share
// the same stimulus and memory responder; expected requests are queued per DUT.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } txn_t;

    logic        clk;
    logic        rst;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        data_req;
    logic        data_we;
    logic [3:0]  data_be;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        mem_ack;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    logic [31:0] aInstRdata, aDataRdata, aMemAddr, aMemWdata;
    logic        aStall, aMemReq, aMemWe;
    logic [3:0]  aMemBe;
    logic [31:0] bInstRdata, bDataRdata, bMemAddr, bMemWdata;
    logic        bStall, bMemReq, bMemWe;
    logic [3:0]  bMemBe;

    txn_t        sbA[$];
    txn_t        sbB[$];
    logic [31:0] rdQ[$];
    txn_t        expA;
    txn_t        expB;

    int          vectors;
    int          miscompares;
    int          ackDelay;
    int          reqCycles;
    int          reqHighCnt;
    bit          respPending;
    bit          holdResp;
    bit          strayRvalid;
    logic [31:0] respData;
    int          stallCycles;

    mem_arbiter #(.AW(32), .DW(32), .DATA_FIRST(1'b1)) dutA (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(aInstRdata),
        .data_req(data_req), .data_we(data_we), .data_be(data_be),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(aDataRdata),
        .stall(aStall), .mem_req(aMemReq), .mem_we(aMemWe), .mem_be(aMemBe),
        .mem_addr(aMemAddr), .mem_wdata(aMemWdata),
        .mem_ack(mem_ack), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    mem_arbiter #(.AW(32), .DW(32), .DATA_FIRST(1'b0)) dutB (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(bInstRdata),
        .data_req(data_req), .data_we(data_we), .data_be(data_be),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(bDataRdata),
        .stall(bStall), .mem_req(bMemReq), .mem_we(bMemWe), .mem_be(bMemBe),
        .mem_addr(bMemAddr), .mem_wdata(bMemWdata),
        .mem_ack(mem_ack), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic txn_t mkTxn(input logic [31:0] addr, input logic we,
                                   input logic [3:0] be, input logic [31:0] wdata);
        txn_t t;
        t.addr  = addr;
        t.we    = we;
        t.be    = be;
        t.wdata = wdata;
        return t;
    endfunction

    // Memory model: checks every request cycle against the scoreboard front,
    // acks after ackDelay extra cycles and returns the next queued word a cycle later.
    always @(negedge clk) begin
        mem_ack    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        if (aMemReq) reqHighCnt++;
        if (!rst) begin
            reqCycles   = 0;
            respPending = 1'b0;
        end else if (strayRvalid) begin
            mem_rvalid  = 1'b1;
            mem_rdata   = 32'h5555_5555;
            strayRvalid = 1'b0;
        end else if (respPending) begin
            mem_rvalid  = 1'b1;
            mem_rdata   = respData;
            respPending = 1'b0;
        end else if (aMemReq) begin
            if (sbA.size() == 0) begin
                checkOutput("unexpected_req_a", 64'd1, 64'd0);
            end else begin
                expA = sbA[0];
                checkOutput("a_mem_addr", aMemAddr, expA.addr);
                checkOutput("a_mem_we", aMemWe, expA.we);
                checkOutput("a_mem_be", aMemBe, expA.be);
                if (expA.we) checkOutput("a_mem_wdata", aMemWdata, expA.wdata);
            end
            if (reqCycles == ackDelay) begin
                mem_ack   = 1'b1;
                reqCycles = 0;
                if (sbA.size() > 0) void'(sbA.pop_front());
                if (sbB.size() > 0) begin
                    expB = sbB.pop_front();
                    checkOutput("b_mem_req", bMemReq, 1'b1);
                    checkOutput("b_mem_addr", bMemAddr, expB.addr);
                    checkOutput("b_mem_we", bMemWe, expB.we);
                    checkOutput("b_mem_be", bMemBe, expB.be);
                end else begin
                    checkOutput("unexpected_req_b", 64'd1, 64'd0);
                end
                if (!holdResp) begin
                    respPending = 1'b1;
                    respData    = 32'hDEAD_0000;
                    if (rdQ.size() > 0) respData = rdQ.pop_front();
                end
            end else begin
                reqCycles++;
            end
        end
    end

    task automatic applyStimulus(input logic iReq, input logic [31:0] iAddr,
                                 input logic dReq, input logic dWe, input logic [3:0] dBe,
                                 input logic [31:0] dAddr, input logic [31:0] dWdata);
        @(negedge clk);
        inst_req   = iReq;
        inst_addr  = iAddr;
        data_req   = dReq;
        data_we    = dWe;
        data_be    = dBe;
        data_addr  = dAddr;
        data_wdata = dWdata;
    endtask

    task automatic waitStallLow(output int cycles);
        cycles = 0;
        #1;
        while (aStall && cycles < 50) begin
            @(negedge clk);
            #1;
            cycles++;
        end
        if (aStall) checkOutput("stall_timeout", aStall, 1'b0);
    endtask

    task automatic dropRequests();
        inst_req = 1'b0;
        data_req = 1'b0;
        data_we  = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        ackDelay    = 0;
        reqCycles   = 0;
        reqHighCnt  = 0;
        respPending = 1'b0;
        holdResp    = 1'b0;
        strayRvalid = 1'b0;
        respData    = '0;
        rst         = 1'b0;
        inst_req    = 1'b0;
        inst_addr   = '0;
        data_req    = 1'b0;
        data_we     = 1'b0;
        data_be     = '0;
        data_addr   = '0;
        data_wdata  = '0;
        mem_ack     = 1'b0;
        mem_rvalid  = 1'b0;
        mem_rdata   = '0;

        repeat (3) @(negedge clk);
        #1;
        checkOutput("rst_stall", aStall, 1'b0);
        checkOutput("rst_mem_req", aMemReq, 1'b0);
        checkOutput("rst_mem_addr", aMemAddr, 32'h0);
        checkOutput("rst_mem_be", aMemBe, 4'h0);
        checkOutput("rst_inst_rdata", aInstRdata, 32'h0);
        checkOutput("rst_data_rdata", aDataRdata, 32'h0);
        rst = 1'b1;

        // Fetch only: three stall cycles, one request cycle.
        sbA.push_back(mkTxn(32'h0040_0000, 1'b0, 4'hF, 32'h0));
        sbB.push_back(mkTxn(32'h0040_0000, 1'b0, 4'hF, 32'h0));
        rdQ.push_back(32'h2008_0005);
        applyStimulus(1'b1, 32'h0040_0000, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        reqHighCnt = 0;
        waitStallLow(stallCycles);
        checkOutput("fetch_stall_cycles", stallCycles, 3);
        checkOutput("fetch_req_cycles", reqHighCnt, 1);
        checkOutput("fetch_inst_rdata", aInstRdata, 32'h2008_0005);
        dropRequests();

        // Load and fetch together: A serves data first, B instruction first.
        sbA.push_back(mkTxn(32'h10, 1'b0, 4'hF, 32'h0));
        sbA.push_back(mkTxn(32'h04, 1'b0, 4'hF, 32'h0));
        sbB.push_back(mkTxn(32'h04, 1'b0, 4'hF, 32'h0));
        sbB.push_back(mkTxn(32'h10, 1'b0, 4'hF, 32'h0));
        rdQ.push_back(32'h1111_1111);
        rdQ.push_back(32'h2222_2222);
        applyStimulus(1'b1, 32'h04, 1'b1, 1'b0, 4'h0, 32'h10, 32'h0);
        waitStallLow(stallCycles);
        checkOutput("both_stall_cycles", stallCycles, 6);
        checkOutput("both_a_data_rdata", aDataRdata, 32'h1111_1111);
        checkOutput("both_a_inst_rdata", aInstRdata, 32'h2222_2222);
        checkOutput("both_b_inst_rdata", bInstRdata, 32'h1111_1111);
        checkOutput("both_b_data_rdata", bDataRdata, 32'h2222_2222);
        checkOutput("both_b_stall", bStall, 1'b0);
        dropRequests();

        // Store with a slow ack: request held four cycles, load data untouched.
        ackDelay = 3;
        sbA.push_back(mkTxn(32'h20, 1'b1, 4'b0011, 32'hDEAD_BEEF));
        sbB.push_back(mkTxn(32'h20, 1'b1, 4'b0011, 32'hDEAD_BEEF));
        rdQ.push_back(32'hFFFF_FFFF);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 4'b0011, 32'h20, 32'hDEAD_BEEF);
        reqHighCnt = 0;
        waitStallLow(stallCycles);
        checkOutput("store_stall_cycles", stallCycles, 6);
        checkOutput("store_req_cycles", reqHighCnt, 4);
        checkOutput("store_a_data_rdata", aDataRdata, 32'h1111_1111);
        checkOutput("store_b_data_rdata", bDataRdata, 32'h2222_2222);
        dropRequests();

        // Store and fetch together with a one-cycle ack delay.
        ackDelay = 1;
        sbA.push_back(mkTxn(32'h40, 1'b1, 4'b1100, 32'hCAFE_F00D));
        sbA.push_back(mkTxn(32'h08, 1'b0, 4'hF, 32'h0));
        sbB.push_back(mkTxn(32'h08, 1'b0, 4'hF, 32'h0));
        sbB.push_back(mkTxn(32'h40, 1'b1, 4'b1100, 32'hCAFE_F00D));
        rdQ.push_back(32'h3333_3333);
        rdQ.push_back(32'h4444_4444);
        applyStimulus(1'b1, 32'h08, 1'b1, 1'b1, 4'b1100, 32'h40, 32'hCAFE_F00D);
        waitStallLow(stallCycles);
        checkOutput("stfe_stall_cycles", stallCycles, 8);
        checkOutput("stfe_a_inst_rdata", aInstRdata, 32'h4444_4444);
        checkOutput("stfe_a_data_rdata", aDataRdata, 32'h1111_1111);
        checkOutput("stfe_b_inst_rdata", bInstRdata, 32'h3333_3333);
        checkOutput("stfe_b_data_rdata", bDataRdata, 32'h2222_2222);
        dropRequests();

        // Back-to-back fetches: the next address arrives right after stall falls.
        ackDelay = 0;
        sbA.push_back(mkTxn(32'h100, 1'b0, 4'hF, 32'h0));
        sbA.push_back(mkTxn(32'h104, 1'b0, 4'hF, 32'h0));
        sbB.push_back(mkTxn(32'h100, 1'b0, 4'hF, 32'h0));
        sbB.push_back(mkTxn(32'h104, 1'b0, 4'hF, 32'h0));
        rdQ.push_back(32'hAAAA_0001);
        rdQ.push_back(32'hAAAA_0002);
        applyStimulus(1'b1, 32'h100, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        waitStallLow(stallCycles);
        checkOutput("b2b_first_stall_cycles", stallCycles, 3);
        checkOutput("b2b_first_rdata", aInstRdata, 32'hAAAA_0001);
        applyStimulus(1'b1, 32'h104, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        waitStallLow(stallCycles);
        checkOutput("b2b_second_stall_cycles", stallCycles, 3);
        checkOutput("b2b_second_rdata", aInstRdata, 32'hAAAA_0002);
        checkOutput("b2b_b_rdata", bInstRdata, 32'hAAAA_0002);
        dropRequests();

        // Reset in the response phase, then a stray response that must be ignored.
        holdResp = 1'b1;
        sbA.push_back(mkTxn(32'h200, 1'b0, 4'hF, 32'h0));
        sbB.push_back(mkTxn(32'h200, 1'b0, 4'hF, 32'h0));
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h200, 32'h0);
        @(negedge clk);
        @(negedge clk);
        #1;
        checkOutput("mid_state_resp", dutA.r_state, ST_RESP);
        rst = 1'b0;
        #1;
        checkOutput("mid_rst_stall", aStall, 1'b0);
        checkOutput("mid_rst_mem_req", aMemReq, 1'b0);
        checkOutput("mid_rst_mem_addr", aMemAddr, 32'h0);
        checkOutput("mid_rst_state", dutA.r_state, ST_IDLE);
        dropRequests();
        @(negedge clk);
        rst         = 1'b1;
        holdResp    = 1'b0;
        strayRvalid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        checkOutput("stray_data_rdata", aDataRdata, 32'h0);
        checkOutput("stray_inst_rdata", aInstRdata, 32'h0);
        checkOutput("stray_stall", aStall, 1'b0);
        checkOutput("stray_mem_req", aMemReq, 1'b0);
        checkOutput("stray_state", dutA.r_state, ST_IDLE);
        checkOutput("stray_data_done", dutA.r_data_done, 1'b0);
        checkOutput("stray_inst_done", dutA.r_inst_done, 1'b0);
        checkOutput("sb_a_empty", sbA.size(), 0);
        checkOutput("sb_b_empty", sbB.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
